// File: rtl/gate_vector_sequencer.sv
// Purpose : applies every input vector of a 1/2-input logic gate, checks the
//           response against the expected gate function and reports errors.
// Latency : DONE pulses N*(SETTLE+1)+1 cycles after START is accepted (N = 2 or 4).
// Backpressure: none; START is only honoured in IDLE and ignored while a run is active.
// Ports   : clk/rst_n clock and async active-low reset; start/mode run request and
//           expected gate; x gate response; a/b stimulus; busy/done/pass status;
//           err_cnt mismatch count; fail_vec index of the first mismatching vector.
module gate_vector_sequencer #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] mode,
  input  logic       x,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [1:0] fail_vec
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_FINISH
  } state_t;

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_t     state_q;
  state_t     state_d;
  logic [2:0] mode_q;
  logic [1:0] idx_q;
  logic [1:0] idx_nxt;
  logic [3:0] cnt_q;
  logic       two_vec;
  logic       last_vec;
  logic       expected;
  logic       mismatch;

  // NOT and BUF only have one operand, so they need just two vectors.
  assign two_vec  = (mode_q[2:1] == 2'b00);
  assign last_vec = two_vec ? (idx_q == 2'd1) : (idx_q == 2'd3);
  assign idx_nxt  = idx_q + 2'd1;

  always_comb begin
    expected = 1'b0;
    case (mode_q)
      3'd0:    expected = ~a;
      3'd1:    expected = a;
      3'd2:    expected = a & b;
      3'd3:    expected = a | b;
      3'd4:    expected = ~(a & b);
      3'd5:    expected = ~(a | b);
      3'd6:    expected = a ^ b;
      default: expected = ~(a ^ b);
    endcase
  end

  assign mismatch = (state_q == S_SAMPLE) && (x != expected);

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_DRIVE;
      end
      S_DRIVE: begin
        busy = 1'b1;
        if (cnt_q == 4'd0) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        busy    = 1'b1;
        state_d = last_vec ? S_FINISH : S_DRIVE;
      end
      default: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: stimulus, vector index, settle counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= 3'd0;
      idx_q    <= 2'd0;
      cnt_q    <= 4'd0;
      a        <= 1'b0;
      b        <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= 3'd0;
      fail_vec <= 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_q   <= mode;
            idx_q    <= 2'd0;
            cnt_q    <= SETTLE_M1;
            a        <= 1'b0;
            b        <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= 3'd0;
            fail_vec <= 2'd0;
          end
        end
        S_DRIVE: begin
          if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        end
        S_SAMPLE: begin
          if (mismatch) begin
            err_cnt <= err_cnt + 3'd1;
            if (err_cnt == 3'd0) fail_vec <= idx_q;
          end
          if (last_vec) begin
            // Include this final sample's outcome in the verdict.
            pass <= (err_cnt == 3'd0) && !mismatch;
            a    <= 1'b0;
            b    <= 1'b0;
          end else begin
            idx_q <= idx_nxt;
            cnt_q <= SETTLE_M1;
            if (two_vec) begin
              a <= idx_nxt[0];
              b <= 1'b0;
            end else begin
              a <= idx_nxt[1];
              b <= idx_nxt[0];
            end
          end
        end
        default: begin
          a <= 1'b0;
          b <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Purpose : self-checking bench for gate_vector_sequencer against a schedule/truth-table model.
// Latency : n/a (bench).
// Backpressure: n/a (bench).
module tb_gate_vector_sequencer;

  localparam int S = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] mode  = 3'd0;
  logic       x     = 1'b0;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_cnt;
  logic [1:0] fail_vec;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gate_vector_sequencer #(.SETTLE(S)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .x        (x),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_cnt  (err_cnt),
    .fail_vec (fail_vec)
  );

  // Truth table of the eight gate kinds.
  function automatic logic gate(input logic [2:0] m, input logic ga, input logic gb);
    case (m)
      3'd0:    return !ga;
      3'd1:    return ga;
      3'd2:    return ga & gb;
      3'd3:    return ga | gb;
      3'd4:    return !(ga & gb);
      3'd5:    return !(ga | gb);
      3'd6:    return ga ^ gb;
      default: return !(ga ^ gb);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One run from an IDLE cycle (cycle 0). gut is the gate actually wired up,
  // flip[v] corrupts its answer on vector v. Leaves the bench in the IDLE cycle after DONE.
  task automatic run(input logic [2:0] m, input logic [2:0] gut, input logic [3:0] flip,
                     input bit scramble, input bit hold);
    int         n;
    int         l;
    int         v;
    int         err;
    logic [1:0] fv;
    logic [1:0] vv;
    logic       ea;
    logic       eb;
    logic       exp_pass;
    n   = (m <= 3'd1) ? 2 : 4;
    l   = n * (S + 1) + 1;
    err = 0;
    fv  = 2'd0;
    for (int k = 0; k < n; k++) begin
      vv = 2'(k);
      ea = (n == 2) ? vv[0] : vv[1];
      eb = (n == 2) ? 1'b0  : vv[0];
      if ((gate(gut, ea, eb) ^ flip[k]) != gate(m, ea, eb)) begin
        if (err == 0) fv = vv;
        err++;
      end
    end
    exp_pass = (err == 0);

    start = 1'b1;
    mode  = m;
    for (int c = 1; c <= l; c++) begin
      tick();
      if (hold)          start = 1'b1;
      else if (scramble && c < l) start = 1'($urandom_range(0, 1));
      else               start = 1'b0;
      if (scramble) mode = 3'($urandom);
      if (c < l) begin
        v  = (c - 1) / (S + 1);
        vv = 2'(v);
        ea = (n == 2) ? vv[0] : vv[1];
        eb = (n == 2) ? 1'b0  : vv[0];
        x  = gate(gut, ea, eb) ^ flip[v];
      end else begin
        ea = 1'b0;
        eb = 1'b0;
        x  = 1'($urandom);
      end
      check($sformatf("a m%0d c%0d", m, c), a, ea);
      check($sformatf("b m%0d c%0d", m, c), b, eb);
      check($sformatf("busy m%0d c%0d", m, c), busy, (c < l));
      check($sformatf("done m%0d c%0d", m, c), done, (c == l));
      if (c == 1) begin
        check($sformatf("clr_err m%0d", m), err_cnt, 0);
        check($sformatf("clr_pass m%0d", m), pass, 0);
        check($sformatf("clr_fv m%0d", m), fail_vec, 0);
      end
      if (c == l) begin
        check($sformatf("pass m%0d", m), pass, exp_pass);
        check($sformatf("err_cnt m%0d", m), err_cnt, err);
        check($sformatf("fail_vec m%0d", m), fail_vec, fv);
      end
    end
    tick();
    check($sformatf("idle_busy m%0d", m), busy, 0);
    check($sformatf("idle_done m%0d", m), done, 0);
    check($sformatf("idle_a m%0d", m), a, 0);
    check($sformatf("idle_b m%0d", m), b, 0);
    check($sformatf("hold_pass m%0d", m), pass, exp_pass);
    check($sformatf("hold_err m%0d", m), err_cnt, err);
    check($sformatf("hold_fv m%0d", m), fail_vec, fv);
  endtask

  initial begin
    logic [2:0] rm;
    logic [2:0] rg;
    #1;
    check("rst_a", a, 0);
    check("rst_b", b, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_cnt, 0);
    check("rst_fv", fail_vec, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    run(3'd0, 3'd0, 4'b0000, 1'b0, 1'b0);   // NOT, correct gate
    run(3'd2, 3'd2, 4'b1000, 1'b0, 1'b0);   // AND with x tied 0
    run(3'd6, 3'd6, 4'b1001, 1'b0, 1'b0);   // XOR with x tied 1
    run(3'd1, 3'd1, 4'b0011, 1'b0, 1'b0);   // BUF, both vectors wrong
    run(3'd4, 3'd4, 4'b0100, 1'b1, 1'b0);   // NAND, start/mode scrambled while busy
    run(3'd7, 3'd7, 4'b0000, 1'b0, 1'b1);   // XNOR, start held high: back-to-back
    run(3'd7, 3'd7, 4'b0000, 1'b0, 1'b1);
    run(3'd7, 3'd7, 4'b0000, 1'b0, 1'b0);

    // Abort an OR run with reset in cycle 5.
    start = 1'b1;
    mode  = 3'd3;
    x     = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      start = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_a", a, 0);
    check("abort_b", b, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_err", err_cnt, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("abort_nodone", done, 0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("post_rst_idle", busy, 0);
    end
    run(3'd3, 3'd3, 4'b0000, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      rm = 3'($urandom);
      rg = ($urandom_range(0, 3) == 0) ? 3'($urandom) : rm;
      run(rm, rg, 4'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
